result_buf_writer: RTL and testbench

RESULT_BUF_WRITER -- requirements
Module: result_buf_writer

---
 rtl/result_buf_writer.sv | 167 ++++++++++++++++
 tb/tb_result_buf_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_buf_writer.sv
`default_nettype none
// ============================================================================
// Module      : result_buf_writer
// Description : Collects one frame of NUM_CLASS unsigned class scores into a
//               register buffer, then hands the buffer to the argmax stage.
//               The handoff uses a result enable, a one-cycle running-max clear
//               and a one-cycle frame-done pulse.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a new frame (honoured in IDLE and HOLD only)
//   in_valid     score word present on in_data
//   in_data      class score, unsigned, DATA_WIDTH bits
//   in_ready     score accepted this cycle when in_valid is also high
//   rd_addr      read address from the argmax stage
//   rd_data      registered read data (0 for addresses >= NUM_CLASS)
//   result_en    high while the buffered scores are valid (EVAL, HOLD)
//   result_clr   one-cycle clear pulse on the first cycle of a new frame
//   result_done  argmax stage finished its scan (honoured in EVAL only)
//   frame_done   one-cycle pulse on the first HOLD cycle
//   wr_count     scores accepted in the current frame, saturating
//
// Revision    : 1.0  initial release
// ============================================================================
module result_buf_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CLASS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [3:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  result_en,
    output logic                  result_clr,
    input  logic                  result_done,
    output logic                  frame_done,
    output logic [3:0]            wr_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_EVAL = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    localparam logic [3:0] c_NUM  = 4'(NUM_CLASS);
    localparam logic [3:0] c_LAST = 4'(NUM_CLASS - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            wr_count_q, wr_count_d;
    logic                  clr_q, clr_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem_q [NUM_CLASS];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        clr_d      = 1'b0;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d    = c_FILL;
                    wr_count_d = 4'd0;
                    clr_d      = 1'b1;
                end
            end
            c_FILL: begin
                // The count guard keeps the buffer index in range even if
                // the count were somehow already full.
                if (in_valid && (wr_count_q < c_NUM)) begin
                    wr_en      = 1'b1;
                    wr_count_d = wr_count_q + 4'd1;
                    if (wr_count_q == c_LAST) begin
                        state_d = c_EVAL;
                    end
                end
            end
            c_EVAL: begin
                if (result_done) begin
                    state_d = c_HOLD;
                    done_d  = 1'b1;
                end
            end
            c_HOLD: begin
                if (start) begin
                    state_d    = c_FILL;
                    wr_count_d = 4'd0;
                    clr_d      = 1'b1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Read mux: any address with no matching entry yields zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (rd_addr == 4'(i)) begin
                rd_data_d = mem_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_IDLE;
            wr_count_q <= 4'd0;
            clr_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            clr_q      <= clr_d;
            done_q     <= done_d;
            // Sampled from the pre-edge buffer contents, so a read that
            // coincides with a write to the same entry returns old data.
            rd_data_q  <= rd_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Score buffer, one register per class
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASS; gi++) begin : g_entry
            localparam logic [3:0] c_IDX = 4'(gi);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (wr_count_q == c_IDX)) begin
                    mem_q[gi] <= in_data;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = (state_q == c_FILL);
    assign result_en  = (state_q == c_EVAL) || (state_q == c_HOLD);
    assign result_clr = clr_q;
    assign frame_done = done_q;
    assign wr_count   = wr_count_q;
    assign rd_data    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_result_buf_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_buf_writer
// Description : Directed self-checking bench for result_buf_writer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_result_buf_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        result_en;
    logic        result_clr;
    logic        result_done;
    logic        frame_done;
    logic [3:0]  wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    result_buf_writer #(
        .DATA_WIDTH (16),
        .NUM_CLASS  (10)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .result_en   (result_en),
        .result_clr  (result_clr),
        .result_done (result_done),
        .frame_done  (frame_done),
        .wr_count    (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ready_cycles;

        rst         = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        rd_addr     = 4'd0;
        result_done = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_result_en",  result_en,  0);
        chk("rst_result_clr", result_clr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_count",   wr_count,   0);
        chk("rst_rd_data",    rd_data,    0);
        rst = 1'b0;

        // first cycle after release is plain IDLE; result_done is ignored
        result_done = 1'b1;
        step();
        result_done = 1'b0;
        chk("idle_in_ready",   in_ready,   0);
        chk("idle_frame_done", frame_done, 0);

        // ---------------- back-to-back fill 100..109 ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f1_clr_pulse", result_clr, 1);
        chk("f1_en_low",    result_en,  0);
        chk("f1_count0",    wr_count,   0);
        ready_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(100 + k);
            if (in_ready) ready_cycles++;
            step();
            if (k == 0) chk("f1_clr_one_cycle", result_clr, 0);
        end
        in_valid = 1'b0;
        chk("f1_ready_cycles", ready_cycles, 10);
        chk("f1_eval_ready",   in_ready,     0);
        chk("f1_eval_en",      result_en,    1);
        chk("f1_count10",      wr_count,     10);
        for (int a = 0; a < 10; a++) begin
            rd_addr = 4'(a);
            step();
            chk("f1_read", rd_data, 100 + a);
        end

        // ---------------- EVAL -> HOLD ----------------
        result_done = 1'b1;
        step();
        result_done = 1'b0;
        chk("eval_frame_done", frame_done, 1);
        chk("eval_clr_low",    result_clr, 0);
        chk("hold_en",         result_en,  1);
        step();
        chk("hold_fd_single",  frame_done, 0);
        chk("hold_en2",        result_en,  1);
        rd_addr = 4'd12;
        step();
        chk("hold_rd12", rd_data, 0);
        rd_addr = 4'd15;
        step();
        chk("hold_rd15", rd_data, 0);
        rd_addr = 4'd5;
        step();
        chk("hold_rd5", rd_data, 105);

        // ---------------- HOLD -> new frame, toggling in_valid ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f2_clr_pulse", result_clr, 1);
        chk("f2_en_low",    result_en,  0);
        chk("f2_count0",    wr_count,   0);
        chk("f2_fd_low",    frame_done, 0);
        for (int c = 0; c < 20; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 16'(200 + c / 2);
            if (c == 0) rd_addr = 4'd0;
            step();
            if (c == 0) chk("f2_same_addr_old", rd_data, 100);
            if (c == 9) chk("f2_count_mid", wr_count, 5);
        end
        chk("f2_count10", wr_count,  10);
        chk("f2_eval_en", result_en, 1);
        in_valid = 1'b1;
        in_data  = 16'd999;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("f2_no_extra_ready", in_ready, 0);
            chk("f2_no_extra_count", wr_count, 10);
        end
        in_valid = 1'b0;
        for (int a = 0; a < 10; a++) begin
            rd_addr = 4'(a);
            step();
            chk("f2_read", rd_data, 200 + a);
        end

        // ---------------- start during FILL ignored ----------------
        result_done = 1'b1;
        step();
        result_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(300 + k);
            start    = (k >= 4 && k < 6);
            step();
            chk("f3_count_seq", wr_count,   k + 1);
            chk("f3_clr_low",   result_clr, 0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("f3_eval_en", result_en, 1);
        rd_addr = 4'd4;
        step();
        chk("f3_read4", rd_data, 304);

        // ---------------- reset mid-FILL ----------------
        result_done = 1'b1;
        step();
        result_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(400 + k);
            step();
        end
        in_valid = 1'b0;
        rd_addr  = 4'd0;
        step();
        chk("f4_pre_rst_rd0", rd_data,  400);
        chk("f4_pre_rst_cnt", wr_count, 6);
        #2;
        rst = 1'b1;
        #1;
        chk("f4_rst_ready", in_ready,   0);
        chk("f4_rst_en",    result_en,  0);
        chk("f4_rst_clr",   result_clr, 0);
        chk("f4_rst_fd",    frame_done, 0);
        chk("f4_rst_cnt",   wr_count,   0);
        chk("f4_rst_rd",    rd_data,    0);
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd777;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("f4_wait_ready", in_ready, 0);
            chk("f4_wait_cnt",   wr_count, 0);
            chk("f4_read_zero",  rd_data,  0);
        end
        in_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f4_restart_ready", in_ready,   1);
        chk("f4_restart_clr",   result_clr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
`default_nettype wire
